alu_packet_sequencer: RTL

Packet-level controller between the UART receive stream, a shared 32-bit ALU and the UART transmit stream. Parses framed command packets from the RX AXI-stream, sequences the operands through the external ALU one operation at a time, and serialises the 32-bit result back onto the TX AXI-stream LSB-first. Also handles the echo command, and drops malformed packets without disturbing framing.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/byte_packer.sv | 56 +++++
 rtl/alu_packet_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU packet sequencer
package alu_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int HDR_BYTES     = 4;
    localparam int OPERAND_BYTES = 4;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;

    typedef enum logic [2:0] {
        HDR,
        ECHO,
        LOAD,
        REQ,
        WAIT,
        RESULT,
        DRAIN
    } state_e;

    typedef enum logic {
        ALU_ADD,
        ALU_MUL
    } alu_op_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian 4-byte shift-in / serialise-out word register
module byte_packer
    import alu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [DATA_WIDTH-1:0] byte_i,
    input  logic [31:0]           word_i,
    output logic [31:0]           word_o,
    output logic [31:0]           shifted_word_o,
    output logic [DATA_WIDTH-1:0] byte_o,
    output logic                  last_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    // Next word/index: a parallel load wins, then clear, then shift-in, then serialise advance
    always_comb begin
        shifted_word_o = word_q;
        shifted_word_o[{idx_q, 3'b000} +: 8] = byte_i;
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 2'd0;
        end else if (clear_i) begin
            idx_d  = 2'd0;
        end else if (shift_i) begin
            word_d = shifted_word_o;
            idx_d  = idx_q + 2'd1;
        end else if (advance_i) begin
            idx_d  = idx_q + 2'd1;
        end
    end

    // Word and shared byte index registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = word_q;
    assign byte_o = word_q[{idx_q, 3'b000} +: 8];
    assign last_o = (idx_q == 2'(OPERAND_BYTES - 1));

endmodule

// File: rtl/alu_packet_sequencer.sv
// rtl/alu_packet_sequencer.sv - packet parser sequencing operands through an external ALU
module alu_packet_sequencer
    import alu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] rx_tdata_i,
    input  logic                  rx_tvalid_i,
    output logic                  rx_tready_o,
    output logic [DATA_WIDTH-1:0] tx_tdata_o,
    output logic                  tx_tvalid_o,
    input  logic                  tx_tready_i,
    output logic                  alu_op_o,
    output logic [31:0]           alu_a_o,
    output logic [31:0]           alu_b_o,
    output logic                  alu_valid_o,
    input  logic                  alu_ready_i,
    input  logic [31:0]           alu_result_i,
    input  logic                  alu_result_valid_i,
    output logic                  drop_o
);

    state_e          state_q, state_d;
    logic [1:0]      hdr_cnt_q, hdr_cnt_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     rem_q, rem_d;
    logic            first_q, first_d;
    alu_op_e         op_q, op_d;
    logic [31:0]     acc_q, acc_d;
    logic [7:0]      echo_data_q, echo_data_d;
    logic            echo_valid_q, echo_valid_d;
    logic            drop_q, drop_d;

    logic            rx_ready;
    logic            rx_fire;
    logic [15:0]     hdr_len;

    logic            pk_clear, pk_shift, pk_load, pk_advance;
    logic [31:0]     pk_word_in, pk_word, pk_shifted;
    logic [7:0]      pk_byte;
    logic            pk_last;

    byte_packer u_packer (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .clear_i        (pk_clear),
        .shift_i        (pk_shift),
        .load_i         (pk_load),
        .advance_i      (pk_advance),
        .byte_i         (rx_tdata_i),
        .word_i         (pk_word_in),
        .word_o         (pk_word),
        .shifted_word_o (pk_shifted),
        .byte_o         (pk_byte),
        .last_o         (pk_last)
    );

    // RX readiness per state; echo stops accepting once its payload is in and waits for TX to drain
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            HDR, LOAD, DRAIN: rx_ready = 1'b1;
            ECHO:             rx_ready = (rem_q != 16'd0) && (tx_tready_i || !echo_valid_q);
            default:          rx_ready = 1'b0;
        endcase
        rx_fire = rx_tvalid_i && rx_ready;
        hdr_len = {rx_tdata_i, len_lo_q};
    end

    // Next-state and datapath updates for the packet FSM
    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        opcode_d     = opcode_q;
        len_lo_d     = len_lo_q;
        rem_d        = rem_q;
        first_d      = first_q;
        op_d         = op_q;
        acc_d        = acc_q;
        echo_data_d  = echo_data_q;
        echo_valid_d = echo_valid_q;
        drop_d       = 1'b0;
        pk_clear     = 1'b0;
        pk_shift     = 1'b0;
        pk_load      = 1'b0;
        pk_advance   = 1'b0;
        pk_word_in   = acc_q;

        if (echo_valid_q && tx_tready_i) begin
            echo_valid_d = 1'b0;
        end

        case (state_q)
            HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: opcode_d = rx_tdata_i;
                        2'd2: len_lo_d = rx_tdata_i;
                        2'd3: begin
                            rem_d = hdr_len - 16'(HDR_BYTES);
                            if (opcode_q == OP_ECHO && hdr_len >= 16'(HDR_BYTES)) begin
                                state_d = (hdr_len == 16'(HDR_BYTES)) ? HDR : ECHO;
                            end else if ((opcode_q == OP_ADD || opcode_q == OP_MUL) &&
                                         hdr_len >= 16'd8 && hdr_len[1:0] == 2'b00) begin
                                state_d  = LOAD;
                                first_d  = 1'b1;
                                op_d     = (opcode_q == OP_MUL) ? ALU_MUL : ALU_ADD;
                                pk_clear = 1'b1;
                            end else begin
                                drop_d  = 1'b1;
                                state_d = (hdr_len <= 16'(HDR_BYTES)) ? HDR : DRAIN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ECHO: begin
                if (rx_fire) begin
                    echo_data_d  = rx_tdata_i;
                    echo_valid_d = 1'b1;
                    rem_d        = rem_q - 16'd1;
                end
                if (rem_q == 16'd0 && (!echo_valid_q || tx_tready_i)) begin
                    state_d = HDR;
                end
            end
            LOAD: begin
                if (rx_fire) begin
                    pk_shift = 1'b1;
                    rem_d    = rem_q - 16'd1;
                    if (pk_last) begin
                        if (first_q) begin
                            // First operand seeds the accumulator without an ALU trip
                            acc_d   = pk_shifted;
                            first_d = 1'b0;
                            if (rem_q == 16'd1) begin
                                state_d    = RESULT;
                                pk_load    = 1'b1;
                                pk_word_in = pk_shifted;
                            end
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
            end
            REQ: begin
                if (alu_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (alu_result_valid_i) begin
                    acc_d = alu_result_i;
                    if (rem_q != 16'd0) begin
                        state_d = LOAD;
                    end else begin
                        state_d    = RESULT;
                        pk_load    = 1'b1;
                        pk_word_in = alu_result_i;
                    end
                end
            end
            RESULT: begin
                if (tx_tready_i) begin
                    pk_advance = 1'b1;
                    if (pk_last) begin
                        state_d = HDR;
                    end
                end
            end
            DRAIN: begin
                if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    // FSM state and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= HDR;
            hdr_cnt_q    <= '0;
            opcode_q     <= '0;
            len_lo_q     <= '0;
            rem_q        <= '0;
            first_q      <= 1'b0;
            op_q         <= ALU_ADD;
            acc_q        <= '0;
            echo_data_q  <= '0;
            echo_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            opcode_q     <= opcode_d;
            len_lo_q     <= len_lo_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            echo_data_q  <= echo_data_d;
            echo_valid_q <= echo_valid_d;
            drop_q       <= drop_d;
        end
    end

    // Handshake outputs are masked by reset so pending valids vanish as soon as reset is raised
    assign rx_tready_o = !reset_i && rx_ready;
    assign tx_tvalid_o = !reset_i && ((state_q == RESULT) || echo_valid_q);
    assign tx_tdata_o  = (state_q == RESULT) ? pk_byte : echo_data_q;
    assign alu_valid_o = !reset_i && (state_q == REQ);
    assign alu_op_o    = (op_q == ALU_MUL);
    assign alu_a_o     = acc_q;
    assign alu_b_o     = pk_word;
    assign drop_o      = !reset_i && drop_q;

endmodule
